// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: walks IDLE/DATA/PARITY/CRC/STOP per trigger,
// latches frame config at start, and flags completion and stop-bit errors.
module uart_rx_frame_ctrl #(
    parameter int DATA_BITS_MAX = 9,
    parameter int CRC_W         = 8,
    parameter int CNT_W         = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             trigger_i,
    input  logic             sampled_start_i,
    input  logic             rx_bit_i,
    input  logic             abort_i,
    input  logic [4:0]       cfg_data_bits_i,
    input  logic [1:0]       cfg_parity_i,
    input  logic             cfg_crc_en_i,
    input  logic             cfg_stop2_i,
    output logic             is_rx_idle_o,
    output logic             is_rx_data_o,
    output logic             is_rx_parity_o,
    output logic             is_rx_crc_o,
    output logic             is_rx_stop_o,
    output logic [CNT_W-1:0] bit_idx_o,
    output logic             shift_en_o,
    output logic [1:0]       parity_mode_o,
    output logic             changed_rx_state_o,
    output logic             frame_done_o,
    output logic             frame_err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_PAR  = 3'd2,
        S_CRC  = 3'd3,
        S_STOP = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(5);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(DATA_BITS_MAX);
    localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [4:0]       MAX5     = 5'(DATA_BITS_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nbits_q, nbits_d, nbits_clamp;
    logic [1:0]       par_q, par_d;
    logic             crc_q, crc_d;
    logic             stop2_q, stop2_d;
    logic             serr_q, serr_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             frame_end;
    logic             load_cfg;

    // Clamp the requested data length into the supported range
    always_comb begin
        nbits_clamp = CNT_W'(cfg_data_bits_i);
        if (cfg_data_bits_i < 5'd5) begin
            nbits_clamp = MIN_C;
        end else if (cfg_data_bits_i > MAX5) begin
            nbits_clamp = MAX_C;
        end
    end

    // Next-state logic; abort overrides any trigger-driven move
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger_i && sampled_start_i) state_d = S_DATA;
            end
            S_DATA: begin
                if (trigger_i && cnt_q == nbits_q - ONE_C) begin
                    if (crc_q) begin
                        state_d = S_CRC;
                    end else if (par_q == 2'b01 || par_q == 2'b10) begin
                        state_d = S_PAR;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (trigger_i) state_d = S_STOP;
            end
            S_CRC: begin
                if (trigger_i && cnt_q == CRC_LAST) state_d = S_STOP;
            end
            S_STOP: begin
                if (trigger_i && cnt_q == (stop2_q ? ONE_C : '0)) begin
                    state_d   = S_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d   = S_IDLE;
            frame_end = 1'b0;
        end
    end

    assign load_cfg = (state_q == S_IDLE) && (state_d == S_DATA);

    // Counter, config latch and stop-error tracking
    always_comb begin
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        par_d   = par_q;
        crc_d   = crc_q;
        stop2_d = stop2_q;
        serr_d  = serr_q;
        done_d  = frame_end;
        err_d   = 1'b0;
        if (abort_i) begin
            if (state_q != S_IDLE) cnt_d = '0;
            serr_d = 1'b0;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end else if (trigger_i) begin
            cnt_d = cnt_q + ONE_C;
        end
        if (load_cfg) begin
            nbits_d = nbits_clamp;
            par_d   = cfg_parity_i;
            crc_d   = cfg_crc_en_i;
            stop2_d = cfg_stop2_i;
            serr_d  = 1'b0;
        end
        if (!abort_i && state_q == S_STOP && trigger_i && !rx_bit_i) begin
            serr_d = 1'b1;
        end
        if (frame_end) begin
            err_d  = serr_q | ~rx_bit_i;
            serr_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nbits_q <= MAX_C;
            par_q   <= 2'b00;
            crc_q   <= 1'b0;
            stop2_q <= 1'b0;
            serr_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            par_q   <= par_d;
            crc_q   <= crc_d;
            stop2_q <= stop2_d;
            serr_q  <= serr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign is_rx_idle_o       = (state_q == S_IDLE);
    assign is_rx_data_o       = (state_q == S_DATA);
    assign is_rx_parity_o     = (state_q == S_PAR);
    assign is_rx_crc_o        = (state_q == S_CRC);
    assign is_rx_stop_o       = (state_q == S_STOP);
    assign bit_idx_o          = cnt_q;
    assign parity_mode_o      = par_q;
    assign shift_en_o         = trigger_i & (is_rx_data_o | is_rx_crc_o);
    assign changed_rx_state_o = (state_d != state_q);
    assign frame_done_o       = done_q;
    assign frame_err_o        = err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random frames checked against
// a per-frame list of expected states built from the frame rules.
module tb_uart_rx_frame_ctrl;

    localparam int DMAX = 9;
    localparam int CRCW = 8;
    localparam int CW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          start = 1'b0;
    logic          rxb = 1'b1;
    logic          abort = 1'b0;
    logic [4:0]    cfg_bits = 5'd8;
    logic [1:0]    cfg_par = 2'b00;
    logic          cfg_crc = 1'b0;
    logic          cfg_s2 = 1'b0;
    logic          s_idle, s_data, s_par, s_crc, s_stop;
    logic [CW-1:0] idx;
    logic          shift_en;
    logic [1:0]    pmode;
    logic          changed;
    logic          done;
    logic          ferr;

    int checks = 0;
    int errs   = 0;

    int exp_st[$];
    int exp_ix[$];

    uart_rx_frame_ctrl #(
        .DATA_BITS_MAX(DMAX),
        .CRC_W(CRCW),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .trigger_i(trig),
        .sampled_start_i(start),
        .rx_bit_i(rxb),
        .abort_i(abort),
        .cfg_data_bits_i(cfg_bits),
        .cfg_parity_i(cfg_par),
        .cfg_crc_en_i(cfg_crc),
        .cfg_stop2_i(cfg_s2),
        .is_rx_idle_o(s_idle),
        .is_rx_data_o(s_data),
        .is_rx_parity_o(s_par),
        .is_rx_crc_o(s_crc),
        .is_rx_stop_o(s_stop),
        .bit_idx_o(idx),
        .shift_en_o(shift_en),
        .parity_mode_o(pmode),
        .changed_rx_state_o(changed),
        .frame_done_o(done),
        .frame_err_o(ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int c);
        logic [31:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] flags();
        return {27'd0, s_stop, s_crc, s_par, s_data, s_idle};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4-clock bit slot: trigger cycle, then three quiet cycles.
    task automatic slot(input logic st, input logic b, input logic ab,
                        input int code, input int ix, input logic chg,
                        input logic dn, input logic er,
                        input logic [1:0] pm);
        trig  = 1'b1;
        start = st;
        rxb   = b;
        abort = ab;
        #1;
        chk($sformatf("state c%0d i%0d", code, ix), flags(), oh(code));
        if (code != 0) begin
            chk($sformatf("idx c%0d", code), 32'(idx), 32'(ix));
            chk("pmode", 32'(pmode), 32'(pm));
        end
        chk($sformatf("shift c%0d", code), 32'(shift_en),
            32'(code == 1 || code == 3));
        chk($sformatf("changed c%0d i%0d", code, ix), 32'(changed), 32'(chg));
        step();
        trig  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rxb   = 1'b1;
        chk("done_after_trig", 32'(done), 32'(dn));
        if (dn) chk("err_at_done", 32'(ferr), 32'(er));
        for (int i = 0; i < 2; i++) begin
            step();
            chk("done_quiet", 32'(done), 32'd0);
        end
        step();
    endtask

    task automatic run_frame(input int bits, input logic [1:0] par,
                             input logic crc, input logic s2,
                             input logic [1:0] stopv, input int abort_at,
                             input int chg_at, input int rst_at);
        int n;
        int last;
        logic b, ab, chg, er;
        n = bits < 5 ? 5 : (bits > DMAX ? DMAX : bits);
        exp_st = {};
        exp_ix = {};
        for (int i = 0; i < n; i++) begin
            exp_st.push_back(1);
            exp_ix.push_back(i);
        end
        if (crc) begin
            for (int i = 0; i < CRCW; i++) begin
                exp_st.push_back(3);
                exp_ix.push_back(i);
            end
        end else if (par == 2'b01 || par == 2'b10) begin
            exp_st.push_back(2);
            exp_ix.push_back(0);
        end
        exp_st.push_back(4);
        exp_ix.push_back(0);
        if (s2) begin
            exp_st.push_back(4);
            exp_ix.push_back(1);
        end
        last = exp_st.size() - 1;
        er = ~stopv[0] | (s2 & ~stopv[1]);
        cfg_bits = 5'(bits);
        cfg_par  = par;
        cfg_crc  = crc;
        cfg_s2   = s2;
        slot(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, par);
        for (int k = 0; k <= last; k++) begin
            if (k == chg_at) begin
                cfg_bits = 5'd5;
                cfg_par  = ~par;
                cfg_crc  = ~crc;
                cfg_s2   = ~s2;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rst_mid_state", flags(), oh(0));
                chk("rst_mid_idx", 32'(idx), 32'd0);
                chk("rst_mid_pm", 32'(pmode), 32'd0);
                chk("rst_mid_done", 32'(done), 32'd0);
                step();
                chk("rst_mid_done2", 32'(done), 32'd0);
                return;
            end
            b = exp_st[k] == 4 ? stopv[exp_ix[k]] : 1'($urandom_range(0, 1));
            ab = (k == abort_at);
            chg = ab || k == last || exp_st[k+1] != exp_st[k];
            slot(1'b0, b, ab, exp_st[k], exp_ix[k], chg,
                 !ab && k == last, er, par);
            if (ab) begin
                chk("abort_state", flags(), oh(0));
                chk("abort_idx", 32'(idx), 32'd0);
                return;
            end
        end
        chk("frame_end_idle", flags(), oh(0));
    endtask

    initial begin
        int b;
        logic [1:0] p;
        logic c, s;
        logic [1:0] sv;
        step();
        step();
        rst = 1'b0;
        chk("rst_state", flags(), oh(0));
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_pm", 32'(pmode), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(ferr), 32'd0);
        chk("rst_changed", 32'(changed), 32'd0);
        chk("rst_shift", 32'(shift_en), 32'd0);
        start = 1'b1;
        #1;
        chk("start_no_trig_chg", 32'(changed), 32'd0);
        step();
        start = 1'b0;
        chk("start_no_trig_state", flags(), oh(0));
        step();
        run_frame(8, 2'b00, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        run_frame(7, 2'b01, 1'b0, 1'b1, 2'b11, -1, -1, -1);
        run_frame(8, 2'b10, 1'b1, 1'b0, 2'b11, -1, -1, -1);
        run_frame(8, 2'b00, 1'b0, 1'b1, 2'b10, -1, -1, -1);
        run_frame(8, 2'b00, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        run_frame(8, 2'b00, 1'b0, 1'b0, 2'b11, 3, -1, -1);
        run_frame(8, 2'b01, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        run_frame(3, 2'b00, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        run_frame(20, 2'b00, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        run_frame(8, 2'b00, 1'b0, 1'b0, 2'b11, -1, 1, -1);
        run_frame(8, 2'b10, 1'b0, 1'b1, 2'b01, -1, -1, -1);
        run_frame(6, 2'b01, 1'b0, 1'b0, 2'b11, -1, -1, 4);
        run_frame(6, 2'b00, 1'b0, 1'b0, 2'b11, -1, -1, -1);
        for (int f = 0; f < 24; f++) begin
            b  = $urandom_range(0, 20);
            p  = 2'($urandom_range(0, 3));
            c  = ($urandom_range(0, 3) == 0);
            s  = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            if ($urandom_range(0, 5) == 0) begin
                run_frame(b, p, c, s, sv, $urandom_range(0, 6), -1, -1);
            end else begin
                run_frame(b, p, c, s, sv, -1, -1, -1);
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Parametrised UART receive frame sequencer and the next-generation RX control path. It owns the bit counter internally and supports a run-time configurable data length, parity mode, CRC field and stop-bit count. Configuration is latched per frame. The block also reports frame completion and stop-bit framing errors. It sits between the baud/sampling datapath, which supplies trigger_i, sampled_start_i and rx_bit_i, and the RX shift/CRC/parity datapath, which consumes the state flags, shift_en_o and bit_idx_o.

Parameters:
DATA_BITS_MAX, 9, maximum data bits per frame (legal range 5..16).
CRC_W, 8, number of CRC bits received when the CRC field is enabled (1..16).
CNT_W, 5, bit counter width; must satisfy 2**CNT_W > max(DATA_BITS_MAX, CRC_W).

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
trigger_i  in  1  one-cycle bit-centre sample strobe.
sampled_start_i  in  1  valid start bit detected; qualified by trigger_i.
rx_bit_i  in  1  sampled line value, valid when trigger_i=1.
abort_i  in  1  synchronous frame abort.
cfg_data_bits_i  in  5  data bits per frame.
cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 none.
cfg_crc_en_i  in  1  receive CRC_W CRC bits instead of a parity bit.
cfg_stop2_i  in  1  0 = one stop bit, 1 = two stop bits.
is_rx_idle_o / is_rx_data_o / is_rx_parity_o / is_rx_crc_o / is_rx_stop_o  out  1 each  one-hot state decode.
bit_idx_o  out  CNT_W  bit index within the current state.
shift_en_o  out  1  trigger_i & (DATA | CRC); shift strobe for the datapath.
parity_mode_o  out  2  latched parity mode, for the datapath checker.
changed_rx_state_o  out  1  state changes at the next clock edge.
frame_done_o  out  1  one-cycle pulse at the end of a completed frame.
frame_err_o  out  1  qualifies frame_done_o; a stop bit was sampled as 0.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, counter 0, latched config = {9-bit clamp, none, crc off, 1 stop}, frame_done_o=0, frame_err_o=0, stop-error flag 0. A reset mid-frame discards the frame, with no done or error pulse.
- Output timing: state flags, bit_idx_o and parity_mode_o are decoded from registers. shift_en_o and changed_rx_state_o are combinational. frame_done_o and frame_err_o are registered.
- State and counter advance only on cycles with trigger_i=1, except abort.
- The counter clears on every state transition and increments on each trigger that stays in the same state.
- Config latch: on the IDLE->DATA transition only. Config changes mid-frame have no effect.
- Data-length clamp: latched nbits = 5 if cfg_data_bits_i<5; DATA_BITS_MAX if cfg_data_bits_i>DATA_BITS_MAX; otherwise cfg_data_bits_i.
- IDLE: trigger & sampled_start_i -> DATA. sampled_start_i without trigger is ignored.
- DATA: trigger & cnt==nbits-1 -> CRC if crc_en, else PARITY if parity in {01,10}, else STOP.
- CRC takes precedence: with crc_en set, parity is never received.
- PARITY: trigger -> STOP.
- CRC: trigger & cnt==CRC_W-1 -> STOP.
- STOP: on each trigger, if rx_bit_i=0 the stop-error flag is set. On trigger & cnt==(stop2?1:0) -> IDLE.
- Frame end: the next cycle, the first cycle in IDLE, has frame_done_o=1 for exactly one clock. In the same cycle frame_err_o = stop-error flag, including the final bit. The flag clears afterwards.
- abort_i=1: state -> IDLE and counter -> 0 at the next edge, regardless of trigger_i. No done or error pulse. abort_i has priority over trigger_i. abort_i in IDLE has no effect.
- changed_rx_state_o = (next_state != state), where next_state includes the abort path.
- Default or illegal state encoding -> IDLE.

Test Plan:
- 8N1 (bits=8, parity=00, crc=0, stop2=0), trigger every 4 clocks, start then 0xA5 then stop=1: 8 shift_en_o pulses with bit_idx_o 0..7, then STOP, then IDLE. frame_done_o=1 and frame_err_o=0 exactly 1 clock after the 10th trigger (the start trigger counts as the 1st).
- 7 data bits, even parity, two stop bits: DATA 7 triggers, PARITY 1, STOP 2, then IDLE; parity_mode_o=01 throughout; is_rx_parity_o high for 4 clocks.
- crc=1, parity=10, bits=8, CRC_W=8: the PARITY state is never entered; 16 shift_en_o pulses total; is_rx_crc_o with bit_idx_o 0..7.
- Two stop bits, first sampled 0, second 1: frame_done_o=1 with frame_err_o=1. The next clean frame gives frame_err_o=0.
- abort_i asserted at DATA bit_idx_o=3, coincident with trigger: IDLE next cycle, bit_idx_o=0, no frame_done_o. A later start begins a fresh frame.
- Clamp and latch: cfg_data_bits_i=3 gives 5 data triggers; cfg_data_bits_i=20 gives DATA_BITS_MAX. Changing cfg_data_bits_i from 8 to 5 during DATA still yields 8 data bits.
